// File: rtl/hwpe_ctrl_package.sv
// Shared types for the HWPE control job scheduler: FSM states, acquire responses, job id width.
package hwpe_ctrl_package;

    localparam int unsigned SCHED_JOB_ID_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        RETIRE = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        GRANTED  = 2'd0,
        CRITICAL = 2'd1,
        FULL     = 2'd2
    } sched_resp_t;

endpackage

// File: rtl/hwpe_ctrl_ctx_ring.sv
// Context ring: prepare pointer, running index and pending-job count over N_CONTEXT slots.
module hwpe_ctrl_ctx_ring #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned LOG_CXT   = 1,
    parameter int unsigned CNT_W     = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    output logic [LOG_CXT-1:0] pointer_o,
    output logic [LOG_CXT-1:0] running_o,
    output logic [CNT_W-1:0]   pending_o,
    output logic               full_o
);

    logic [LOG_CXT-1:0] pointer_q, running_q;
    logic [CNT_W-1:0]   pending_q;

    // Explicit wrap so non-power-of-2 depths never index a missing context.
    function automatic logic [LOG_CXT-1:0] wrap_inc(input logic [LOG_CXT-1:0] idx);
        return (idx == LOG_CXT'(N_CONTEXT - 1)) ? '0 : idx + LOG_CXT'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pointer_q <= '0;
            running_q <= '0;
            pending_q <= '0;
        end else if (clear_i) begin
            pointer_q <= '0;
            running_q <= '0;
            pending_q <= '0;
        end else begin
            if (push_i) pointer_q <= wrap_inc(pointer_q);
            if (pop_i)  running_q <= wrap_inc(running_q);
            case ({push_i, pop_i})
                2'b10:   pending_q <= pending_q + CNT_W'(1);
                2'b01:   pending_q <= pending_q - CNT_W'(1);
                default: pending_q <= pending_q;
            endcase
        end
    end

    assign pointer_o = pointer_q;
    assign running_o = running_q;
    assign pending_o = pending_q;
    assign full_o    = (pending_q == CNT_W'(N_CONTEXT));

endmodule

// File: rtl/hwpe_ctrl_job_scheduler.sv
// Offload-job scheduler: lock test-and-set, context ring, in-order start/retire FSM.
// Optional lock watchdog enabled by defining HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN.
module hwpe_ctrl_job_scheduler
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CONTEXT    = 2,
    parameter int unsigned ID_WIDTH     = 16,
    parameter int unsigned LOCK_TIMEOUT = 256,
    localparam int unsigned LOG_CXT     = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
    localparam int unsigned CNT_W       = $clog2(N_CONTEXT + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          acquire_i,
    input  logic [ID_WIDTH-1:0]           acquire_src_i,
    output logic                          acquire_valid_o,
    output logic [1:0]                    acquire_resp_o,
    output logic [SCHED_JOB_ID_WIDTH-1:0] acquire_job_id_o,
    input  logic                          trigger_i,
    input  logic [ID_WIDTH-1:0]           trigger_src_i,
    output logic                          trigger_err_o,
    output logic                          engine_start_o,
    input  logic                          engine_done_i,
    output logic                          true_done_o,
    output logic [LOG_CXT-1:0]            pointer_context_o,
    output logic [LOG_CXT-1:0]            running_context_o,
    output logic                          full_context_o,
    output logic                          is_critical_o,
    output logic [CNT_W-1:0]              pending_jobs_o,
    output logic                          busy_o
);

    logic                          lock_q;
    logic [ID_WIDTH-1:0]           owner_q;
    logic [SCHED_JOB_ID_WIDTH-1:0] offload_id_q;
    sched_resp_t                   resp_q;
    sched_state_t                  state_q;
    logic                          trigger_ok, grant, pop, full, timeout_fire;
    logic [CNT_W-1:0]              pending;

    assign trigger_ok = trigger_i && lock_q && (trigger_src_i == owner_q);
    assign grant      = acquire_i && !lock_q && !full;
    assign pop        = (state_q == RETIRE);

`ifdef HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;

    // A valid commit in the expiry cycle wins over the watchdog.
    assign timeout_fire = lock_q && !trigger_ok && (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  to_cnt_q <= '0;
        else if (clear_i || grant)    to_cnt_q <= '0;
        else if (lock_q)              to_cnt_q <= to_cnt_q + TO_W'(1);
    end
`else
    assign timeout_fire = 1'b0;
`endif

    hwpe_ctrl_ctx_ring #(
        .N_CONTEXT (N_CONTEXT),
        .LOG_CXT   (LOG_CXT),
        .CNT_W     (CNT_W)
    ) i_ctx_ring (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .push_i    (trigger_ok),
        .pop_i     (pop),
        .pointer_o (pointer_context_o),
        .running_o (running_context_o),
        .pending_o (pending),
        .full_o    (full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q           <= 1'b0;
            owner_q          <= '0;
            offload_id_q     <= '0;
            resp_q           <= GRANTED;
            acquire_job_id_o <= '0;
            acquire_valid_o  <= 1'b0;
            trigger_err_o    <= 1'b0;
        end else if (clear_i) begin
            lock_q           <= 1'b0;
            owner_q          <= '0;
            offload_id_q     <= '0;
            resp_q           <= GRANTED;
            acquire_job_id_o <= '0;
            acquire_valid_o  <= 1'b0;
            trigger_err_o    <= 1'b0;
        end else begin
            acquire_valid_o <= acquire_i;
            trigger_err_o   <= (trigger_i && !trigger_ok) || timeout_fire;
            if (acquire_i) begin
                if (lock_q)     resp_q <= CRITICAL;
                else if (full)  resp_q <= FULL;
                else begin
                    resp_q           <= GRANTED;
                    acquire_job_id_o <= offload_id_q;
                    offload_id_q     <= offload_id_q + SCHED_JOB_ID_WIDTH'(1);
                end
            end
            if (grant) begin
                lock_q  <= 1'b1;
                owner_q <= acquire_src_i;
            end else if (trigger_ok || timeout_fire) begin
                lock_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            engine_start_o <= 1'b0;
            true_done_o    <= 1'b0;
        end else if (clear_i) begin
            state_q        <= IDLE;
            engine_start_o <= 1'b0;
            true_done_o    <= 1'b0;
        end else begin
            engine_start_o <= 1'b0;
            true_done_o    <= 1'b0;
            case (state_q)
                IDLE:   if (pending != '0) state_q <= START;
                START: begin
                    engine_start_o <= 1'b1;
                    state_q        <= RUN;
                end
                RUN:    if (engine_done_i) state_q <= RETIRE;
                RETIRE: begin
                    true_done_o <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign acquire_resp_o = resp_q;
    assign full_context_o = full;
    assign is_critical_o  = lock_q;
    assign pending_jobs_o = pending;
    assign busy_o         = (state_q != IDLE) || (pending != '0);

endmodule

// File: tb/tb_hwpe_ctrl_job_scheduler.sv
// Directed bench for hwpe_ctrl_job_scheduler with an acquire-response scoreboard.
module tb_hwpe_ctrl_job_scheduler;
    import hwpe_ctrl_package::*;

    localparam int unsigned NC = 3;
    localparam int unsigned LC = 2;
    localparam int unsigned CW = 2;

    typedef struct {
        sched_resp_t resp;
        logic [7:0]  id;
    } acq_exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          acquire = 1'b0;
    logic [15:0]   acquire_src = '0;
    logic          acquire_valid;
    logic [1:0]    acquire_resp;
    logic [7:0]    acquire_job_id;
    logic          trigger = 1'b0;
    logic [15:0]   trigger_src = '0;
    logic          trigger_err;
    logic          engine_start;
    logic          engine_done = 1'b0;
    logic          true_done;
    logic [LC-1:0] pointer_context;
    logic [LC-1:0] running_context;
    logic          full_context;
    logic          is_critical;
    logic [CW-1:0] pending_jobs;
    logic          busy;

    int       n_checks = 0;
    int       n_pass = 0;
    acq_exp_t acq_q[$];

    always #5 clk = ~clk;

    hwpe_ctrl_job_scheduler #(
        .N_CONTEXT    (NC),
        .ID_WIDTH     (16),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .clear_i           (clear),
        .acquire_i         (acquire),
        .acquire_src_i     (acquire_src),
        .acquire_valid_o   (acquire_valid),
        .acquire_resp_o    (acquire_resp),
        .acquire_job_id_o  (acquire_job_id),
        .trigger_i         (trigger),
        .trigger_src_i     (trigger_src),
        .trigger_err_o     (trigger_err),
        .engine_start_o    (engine_start),
        .engine_done_i     (engine_done),
        .true_done_o       (true_done),
        .pointer_context_o (pointer_context),
        .running_context_o (running_context),
        .full_context_o    (full_context),
        .is_critical_o     (is_critical),
        .pending_jobs_o    (pending_jobs),
        .busy_o            (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_acquire(input logic [15:0] src, input sched_resp_t r, input logic [7:0] id);
        acq_exp_t e;
        e.resp = r;
        e.id   = id;
        acq_q.push_back(e);
        acquire     = 1'b1;
        acquire_src = src;
        tick();
        acquire = 1'b0;
    endtask

    task automatic do_trigger(input logic [15:0] src);
        trigger     = 1'b1;
        trigger_src = src;
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!engine_start && n < 50) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(engine_start), 32'd1);
    endtask

    task automatic retire();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        tick();
    endtask

    // Scoreboard: every acquire response must match the oldest expectation.
    always @(negedge clk) begin
        if (acquire_valid) begin
            if (acq_q.size() == 0) begin
                chk("acq_unexpected", 32'd1, 32'd0);
            end else begin
                acq_exp_t e;
                e = acq_q.pop_front();
                chk("acq_resp", 32'(acquire_resp), 32'(e.resp));
                if (e.resp == GRANTED) chk("acq_job_id", 32'(acquire_job_id), 32'(e.id));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_valid", 32'(acquire_valid), 32'd0);
        chk("rst_crit", 32'(is_critical), 32'd0);
        chk("rst_pending", 32'(pending_jobs), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pointer", 32'(pointer_context), 32'd0);

        // Single job end to end.
        do_acquire(16'd3, GRANTED, 8'd0);
        chk("t1_crit", 32'(is_critical), 32'd1);
        do_trigger(16'd3);
        chk("t1_pending", 32'(pending_jobs), 32'd1);
        chk("t1_crit_rel", 32'(is_critical), 32'd0);
        chk("t1_pointer", 32'(pointer_context), 32'd1);
        wait_start(n);
        chk("t1_start_latency", 32'(n), 32'd2);
        tick();
        chk("t1_start_pulse", 32'(engine_start), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        retire();
        chk("t1_true_done", 32'(true_done), 32'd1);
        chk("t1_running", 32'(running_context), 32'd1);
        chk("t1_pending0", 32'(pending_jobs), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(true_done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Fill every context with the engine stalled.
        for (int k = 0; k < NC; k++) begin
            do_acquire(16'd7, GRANTED, 8'(k + 1));
            do_trigger(16'd7);
        end
        chk("t2_full", 32'(full_context), 32'd1);
        chk("t2_pending", 32'(pending_jobs), 32'(NC));
        do_acquire(16'd7, FULL, 8'd0);
        chk("t2_no_lock", 32'(is_critical), 32'd0);
        retire();
        chk("t2_pending_after", 32'(pending_jobs), 32'(NC - 1));
        chk("t2_running", 32'd2, 32'(running_context));

        // Lock contention and wrong-owner trigger.
        do_acquire(16'd1, GRANTED, 8'd4);
        do_acquire(16'd2, CRITICAL, 8'd0);
        do_trigger(16'd2);
        chk("t3_err", 32'(trigger_err), 32'd1);
        chk("t3_pending", 32'(pending_jobs), 32'd2);
        chk("t3_still_crit", 32'(is_critical), 32'd1);
        acq_q.push_back('{CRITICAL, 8'd0});
        acquire = 1'b1; acquire_src = 16'd2;
        trigger = 1'b1; trigger_src = 16'd1;
        tick();
        acquire = 1'b0; trigger = 1'b0;
        chk("t3_err_clear", 32'(trigger_err), 32'd0);
        chk("t3_commit", 32'(pending_jobs), 32'd3);
        chk("t3_unlock", 32'(is_critical), 32'd0);
        chk("t3_pointer", 32'(pointer_context), 32'd2);

        // Clear while a job runs.
        retire();
        chk("t5_pending2", 32'(pending_jobs), 32'd2);
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_pending", 32'(pending_jobs), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_pointer", 32'(pointer_context), 32'd0);
        chk("t5_running", 32'(running_context), 32'd0);
        chk("t5_start", 32'(engine_start), 32'd0);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        tick();
        chk("t5_late_done", 32'(true_done), 32'd0);
        chk("t5_still_idle", 32'(busy), 32'd0);

        // Ring wrap with a non-power-of-2 depth, ids restart after clear.
        for (int k = 0; k < 4; k++) begin
            do_acquire(16'd5, GRANTED, 8'(k));
            do_trigger(16'd5);
            wait_start(n);
            chk("t4_running_start", 32'(running_context), 32'(k % NC));
            retire();
            chk("t4_true_done", 32'(true_done), 32'd1);
            chk("t4_running_next", 32'(running_context), 32'((k + 1) % NC));
        end
        for (int k = 4; k < 256; k++) begin
            do_acquire(16'd5, GRANTED, 8'(k));
            do_trigger(16'd5);
            wait_start(n);
            retire();
        end
        do_acquire(16'd9, GRANTED, 8'd0);
        chk("t4_wrap_pointer", 32'(pointer_context), 32'(256 % NC));

`ifdef HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN
        n = 0;
        while (is_critical && n < 100) begin
            tick();
            n++;
        end
        chk("t6_timeout_cycles", 32'(n), 32'd16);
        chk("t6_timeout_err", 32'(trigger_err), 32'd1);
        chk("t6_pointer", 32'(pointer_context), 32'(256 % NC));
        chk("t6_pending", 32'(pending_jobs), 32'd0);
`else
        repeat (1000) tick();
        chk("t6_lock_held", 32'(is_critical), 32'd1);
        chk("t6_pointer", 32'(pointer_context), 32'(256 % NC));
        chk("t6_no_err", 32'(trigger_err), 32'd0);
        do_trigger(16'd9);
        chk("t6_commit", 32'(pending_jobs), 32'd1);
`endif

        repeat (2) tick();
        chk("acq_queue_empty", 32'(acq_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
